sdr_toggle_responder: RTL
=========================

// Module: sdr_toggle_responder
// PURPOSE
//  Memory-side responder for the sdr_req/sdr_ack toggle handshake that video fetch clients (sprite, tile) use.
//  One request is pending while sdr_req != sdr_ack. The block turns it into one command on a valid/ready SDRAM
//  controller port, returns read data on sdr_dout and completes the request by setting sdr_ack = sdr_req.
//  One instance sits between each fetch client and the SDRAM arbiter, in the CLK_96M domain.
// PARAMETERS
//  ADDR_W       24   word address width; addresses are [ADDR_W:1]
//  TIMEOUT_CYC  255  max cycles in WAIT before forced completion (8-bit counter, 1..255)
// PORTS
//  CLK_96M     in   1       single clock, all logic rising-edge
//  RESET_N     in   1       asynchronous, active-low reset
//  sdr_req     in   1       client toggle; request pending while != sdr_ack
//  sdr_ack     out  1       completion toggle, set equal to sdr_req on completion
//  sdr_addr    in   ADDR_W  word address [ADDR_W:1], sampled at request detect
//  sdr_wr_sel  in   2       byte write enables; 2'b00 = read
//  sdr_din     in   16      write data
//  sdr_dout    out  16      read data, valid from the cycle sdr_ack toggles until the next completion
//  mem_req     out  1       command valid, held until mem_ready
//  mem_ready   in   1       controller accepts command on the edge where mem_req&mem_ready
//  mem_addr    out  ADDR_W  command word address
//  mem_we      out  1       1 = write
//  mem_be      out  2       byte enables (= sdr_wr_sel for writes, 2'b11 for reads)
//  mem_wdata   out  16      write data
//  mem_rvalid  in   1       read data strobe, one per accepted read, any latency >= 1
//  mem_rdata   in   16      read data
//  busy        out  1       1 in any state other than IDLE
//  timeout     out  1       one-cycle pulse on forced completion
// BEHAVIOUR
//  - Reset: sdr_ack=0, sdr_dout=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, busy=0,
//    timeout=0, state=IDLE, prefetch buffer invalid. A reset mid-transaction abandons the transaction.
//    mem_rvalid is ignored in every state except WAIT/PF_WAIT.
//  - FSM:
//    IDLE: on sdr_req!=sdr_ack, latch addr/wr_sel/din, go to ISSUE (mem_req=1 next cycle).
//    ISSUE: hold mem_req/addr/we/be/wdata stable until mem_ready.
//      Write accepted: sdr_ack<=sdr_req, go to IDLE.
//      Read accepted: go to WAIT, clear the timeout counter.
//    WAIT: on mem_rvalid, sdr_dout<=mem_rdata and sdr_ack<=sdr_req, go to IDLE.
//      If the counter reaches TIMEOUT_CYC first: sdr_dout<=16'hFFFF, toggle sdr_ack, pulse timeout, go to IDLE.
//  - Minimum read latency: request seen on edge N -> mem_req high after N; mem_ready on N+1 -> WAIT;
//    rvalid on edge M -> sdr_ack toggled after M.
//  - Minimum write latency: ack toggled after edge N+1.
//  - Client inputs may change while a request is pending; only values latched at detect are used.
//  - Only one request may be outstanding. sdr_req toggling again before ack is a protocol violation; it is
//    treated as a new request after the current one completes.
//  - Addresses wrap modulo 2^ADDR_W.
// CONFIGURATION
//  SDR_RESP_PREFETCH_EN defined:
//    - After each completed read of address A with no request pending, issue a speculative read of A+1
//      (wraps {ADDR_W{1}} -> 0) via PF_ISSUE/PF_WAIT.
//    - The result is stored as pf_data/pf_addr/pf_valid.
//    - A read request matching pf_addr while pf_valid is set completes one edge after detect
//      (HIT state, no mem command) and starts prefetch of the next address.
//    - A request arriving during PF_ISSUE/PF_WAIT waits for the prefetch to finish, then checks for a hit.
//    - Any write whose address equals pf_addr clears pf_valid. A prefetch timeout clears pf_valid silently
//      (no timeout pulse).
//  Not defined: no PF/HIT states, no speculative commands; behaviour is exactly the base FSM.
// TESTING
//  1) Read: addr=24'h000100, mem_ready 1 cycle later, rvalid+rdata=16'hA55A 3 cycles later
//     -> one mem cmd (we=0, be=11, addr=0x100), sdr_dout=A55A, sdr_ack toggles after the rvalid edge.
//  2) Write: wr_sel=2'b01, din=16'h1234, mem_ready held low 4 cycles
//     -> mem_req/addr/be=01/wdata stable for 5 cycles, ack toggles on the accept edge, no WAIT entered.
//  3) Timeout with TIMEOUT_CYC=8, read never answered
//     -> sdr_dout=FFFF, timeout pulses once, ack toggles 8 cycles after accept.
//     A later stray rvalid in IDLE changes nothing.
//  4) RESET_N low for 2 cycles while in WAIT -> all outputs at reset values asynchronously.
//     Post-reset rvalid is ignored; the next request is served normally.
//  5) PREFETCH_EN: read 0x200, then read 0x201 -> the second request completes one edge after detect
//     with the prefetched data. Write to 0x202 during the next prefetch window -> the subsequent read of 0x202
//     goes to memory.
//  6) PREFETCH_EN: read of 24'hFFFFFF -> the prefetch command address is 0.

Source files
------------

// File: rtl/sdr_toggle_responder.sv
// -----------------------------------------------------------------------------
// sdr_toggle_responder
//
// Memory-side responder for the sdr_req/sdr_ack toggle handshake used by the
// video fetch clients. A request is pending while sdr_req != sdr_ack. Each
// request becomes one command on a valid/ready SDRAM controller port. Read data
// is returned on sdr_dout. The request completes when sdr_ack toggles.
//
// Optional feature: define SDR_RESP_PREFETCH_EN to enable speculative
// next-word prefetch. Without it the block is the plain IDLE/ISSUE/WAIT FSM.
//
// Ports
//   CLK_96M     in   single clock, rising edge
//   RESET_N     in   asynchronous active-low reset
//   sdr_req     in   client request toggle
//   sdr_ack     out  completion toggle
//   sdr_addr    in   word address [ADDR_W:1], latched at request detect
//   sdr_wr_sel  in   byte write enables, 2'b00 = read
//   sdr_din     in   write data
//   sdr_dout    out  read data (16'hFFFF after a timed-out read)
//   mem_req     out  command valid, held until mem_ready
//   mem_ready   in   command accepted on an edge with mem_req & mem_ready
//   mem_addr    out  command word address
//   mem_we      out  1 = write
//   mem_be      out  byte enables (2'b11 for reads)
//   mem_wdata   out  write data
//   mem_rvalid  in   read data strobe, one per accepted read
//   mem_rdata   in   read data
//   busy        out  high whenever the FSM is not IDLE
//   timeout     out  one-cycle pulse on a forced read completion
// -----------------------------------------------------------------------------
module sdr_toggle_responder #(
    parameter int ADDR_W      = 24,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              CLK_96M,
    input  logic              RESET_N,
    input  logic              sdr_req,
    output logic              sdr_ack,
    input  logic [ADDR_W:1]   sdr_addr,
    input  logic [1:0]        sdr_wr_sel,
    input  logic [15:0]       sdr_din,
    output logic [15:0]       sdr_dout,
    output logic              mem_req,
    input  logic              mem_ready,
    output logic [ADDR_W:1]   mem_addr,
    output logic              mem_we,
    output logic [1:0]        mem_be,
    output logic [15:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata,
    output logic              busy,
    output logic              timeout
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE    = 3'd1;
    localparam logic [2:0] S_WAIT     = 3'd2;
`ifdef SDR_RESP_PREFETCH_EN
    localparam logic [2:0] S_PF_ISSUE = 3'd3;
    localparam logic [2:0] S_PF_WAIT  = 3'd4;
    localparam logic [2:0] S_HIT      = 3'd5;
`endif

    // Last counter value before a forced completion; the counter starts at 0
    // on the accept edge, so completion lands TIMEOUT_CYC edges after accept.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [2:0] state;
    logic [7:0] wait_cnt;
    logic       pending;

`ifdef SDR_RESP_PREFETCH_EN
    logic              pf_valid;
    logic              pf_pend;   // a read just completed; prefetch A+1 if idle
    logic [ADDR_W:1]   pf_addr;
    logic [15:0]       pf_data;
`endif

    assign pending = (sdr_req != sdr_ack);
    assign busy    = (state != S_IDLE);

    // NOTE: every register here is a single flop (no memory arrays), so all of
    // them are cleared by the async reset; state updates use non-blocking <=
    // so every branch sees the pre-edge values.
    always_ff @(posedge CLK_96M or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= S_IDLE;
            wait_cnt  <= 8'd0;
            sdr_ack   <= 1'b0;
            sdr_dout  <= 16'd0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_be    <= 2'b00;
            mem_wdata <= 16'd0;
            timeout   <= 1'b0;
`ifdef SDR_RESP_PREFETCH_EN
            pf_valid  <= 1'b0;
            pf_pend   <= 1'b0;
            pf_addr   <= '0;
            pf_data   <= 16'd0;
`endif
        end else begin
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pending) begin
                        // Latch the client command; later client changes are ignored.
                        mem_addr  <= sdr_addr;
                        mem_we    <= |sdr_wr_sel;
                        mem_be    <= (sdr_wr_sel == 2'b00) ? 2'b11 : sdr_wr_sel;
                        mem_wdata <= sdr_din;
`ifdef SDR_RESP_PREFETCH_EN
                        pf_pend   <= 1'b0;
                        if (sdr_wr_sel == 2'b00 && pf_valid && sdr_addr == pf_addr) begin
                            state <= S_HIT;
                        end else begin
                            if (sdr_wr_sel != 2'b00 && sdr_addr == pf_addr)
                                pf_valid <= 1'b0;
                            mem_req <= 1'b1;
                            state   <= S_ISSUE;
                        end
`else
                        mem_req   <= 1'b1;
                        state     <= S_ISSUE;
`endif
                    end
`ifdef SDR_RESP_PREFETCH_EN
                    else if (pf_pend) begin
                        // mem_addr still holds the last read address; +1 wraps.
                        pf_pend  <= 1'b0;
                        mem_addr <= mem_addr + ADDR_W'(1);
                        mem_we   <= 1'b0;
                        mem_be   <= 2'b11;
                        mem_req  <= 1'b1;
                        state    <= S_PF_ISSUE;
                    end
`endif
                end

                S_ISSUE: begin
                    if (mem_ready) begin
                        mem_req  <= 1'b0;
                        wait_cnt <= 8'd0;
                        if (mem_we) begin
                            // Toggle rather than copy sdr_req so a second,
                            // early toggle stays pending as a new request.
                            sdr_ack <= ~sdr_ack;
                            state   <= S_IDLE;
                        end else begin
                            state   <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (mem_rvalid) begin
                        sdr_dout <= mem_rdata;
                        sdr_ack  <= ~sdr_ack;
                        state    <= S_IDLE;
`ifdef SDR_RESP_PREFETCH_EN
                        pf_pend  <= 1'b1;
`endif
                    end else if (wait_cnt == TO_LAST) begin
                        sdr_dout <= 16'hFFFF;
                        sdr_ack  <= ~sdr_ack;
                        timeout  <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

`ifdef SDR_RESP_PREFETCH_EN
                S_HIT: begin
                    sdr_dout <= pf_data;
                    sdr_ack  <= ~sdr_ack;
                    pf_pend  <= 1'b1;
                    state    <= S_IDLE;
                end

                S_PF_ISSUE: begin
                    if (mem_ready) begin
                        mem_req  <= 1'b0;
                        wait_cnt <= 8'd0;
                        state    <= S_PF_WAIT;
                    end
                end

                S_PF_WAIT: begin
                    if (mem_rvalid) begin
                        pf_data  <= mem_rdata;
                        pf_addr  <= mem_addr;
                        pf_valid <= 1'b1;
                        state    <= S_IDLE;
                    end else if (wait_cnt == TO_LAST) begin
                        // Speculative read lost: drop the buffer quietly.
                        pf_valid <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
`endif

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
